// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract, CHUNK bits per stage, registered carries and valid/ready flow control.
// Define OVERFLOW_FLAG_EN to add the signed-overflow output ovf, aligned with sum.
module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef OVERFLOW_FLAG_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int STAGES = WIDTH / CHUNK;

    // Index 0 is the operand capture register; stage k (1..STAGES) adds slice k-1.
    // x_q/y_q[k-1] feed stage k, s_q[k-1] and carry_q[k] are what stage k produced.
    logic [STAGES:0]  valid_q, valid_d;
    logic [STAGES:0]  carry_q, carry_d;
    logic [WIDTH-1:0] x_q [STAGES];
    logic [WIDTH-1:0] y_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [WIDTH-1:0] x_d [STAGES];
    logic [WIDTH-1:0] y_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             stall;

    function automatic logic [CHUNK:0] add_slice(input logic [CHUNK-1:0] a,
                                                 input logic [CHUNK-1:0] b,
                                                 input logic             c);
        return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
    endfunction

    assign stall     = valid_q[STAGES] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = valid_q[STAGES];
    assign sum       = s_q[STAGES-1];
    assign cout      = carry_q[STAGES];

    always_comb begin
        logic [CHUNK:0] part;
        valid_d    = valid_q;
        carry_d    = carry_q;
        x_d        = x_q;
        y_d        = y_q;
        s_d        = s_q;

        valid_d[0] = in_valid;
        carry_d[0] = cin ^ sub;
        x_d[0]     = x;
        y_d[0]     = y ^ {WIDTH{sub}};

        for (int k = 1; k < STAGES; k++) begin
            x_d[k] = x_q[k-1];
            y_d[k] = y_q[k-1];
        end

        for (int k = 1; k <= STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
        end

        part              = add_slice(x_q[0][CHUNK-1:0], y_q[0][CHUNK-1:0], carry_q[0]);
        s_d[0]            = '0;
        s_d[0][CHUNK-1:0] = part[CHUNK-1:0];
        carry_d[1]        = part[CHUNK];

        // Finished low slices ride along untouched so the whole result leaves at once.
        for (int k = 2; k <= STAGES; k++) begin
            part                               = add_slice(x_q[k-1][(k-1)*CHUNK +: CHUNK],
                                                           y_q[k-1][(k-1)*CHUNK +: CHUNK],
                                                           carry_q[k-1]);
            s_d[k-1]                           = s_q[k-2];
            s_d[k-1][(k-1)*CHUNK +: CHUNK]     = part[CHUNK-1:0];
            carry_d[k]                         = part[CHUNK];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                s_q[i] <= '0;
            end
        end else if (!stall) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic ovf_q;
    logic ovf_d;

    // Carry into the MSB equals a ^ b ^ s at that bit, so overflow needs no extra adder.
    always_comb begin
        ovf_d = x_q[STAGES-1][WIDTH-1] ^ y_q[STAGES-1][WIDTH-1]
              ^ s_d[STAGES-1][WIDTH-1] ^ carry_d[STAGES];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, CHUNK=4): arithmetic queue model plus directed vectors.
module tb_pipelined_adder;

    localparam int LATENCY = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout;
`ifdef OVERFLOW_FLAG_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        v;
    } exp_t;

    exp_t        expq[$];
    int          xfer_count = 0;
    int          run_len = 0;
    int          max_run = 0;
    logic        prev_xfer = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_sum = '0;
    logic        prev_cout = 1'b0;

    pipelined_adder #(.WIDTH(32), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef OVERFLOW_FLAG_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    always #5 clk = ~clk;

    // Whole-word arithmetic reference for one operand beat.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic su);
        logic [31:0] bb;
        logic [32:0] r;
        exp_t        e;
        bb  = b ^ {32{su}};
        r   = {1'b0, a} + {1'b0, bb} + {32'd0, ci ^ su};
        e.s = r[31:0];
        e.c = r[32];
        e.v = (a[31] == bb[31]) && (r[31] != a[31]);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard: sampled on the falling edge, describing what the next rising edge will do.
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            prev_stall = 1'b0;
            prev_xfer  = 1'b0;
        end else begin
            checkOutput("in_ready_rule", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
            if (prev_stall) begin
                checkOutput("stall_valid_hold", {63'd0, out_valid}, 64'd1);
                checkOutput("stall_sum_hold", {32'd0, sum}, {32'd0, prev_sum});
                checkOutput("stall_cout_hold", {63'd0, cout}, {63'd0, prev_cout});
            end
            if (out_valid) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_result", {63'd0, out_valid}, 64'd0);
                end else begin
                    checkOutput("model_sum", {32'd0, sum}, {32'd0, expq[0].s});
                    checkOutput("model_cout", {63'd0, cout}, {63'd0, expq[0].c});
`ifdef OVERFLOW_FLAG_EN
                    checkOutput("model_ovf", {63'd0, ovf}, {63'd0, expq[0].v});
`endif
                    if (out_ready) void'(expq.pop_front());
                end
            end
            if (out_valid && out_ready) begin
                xfer_count++;
                run_len = prev_xfer ? run_len + 1 : 1;
                if (run_len > max_run) max_run = run_len;
            end
            prev_xfer = out_valid && out_ready;
            if (in_valid && in_ready) expq.push_back(model(x, y, cin, sub));
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            prev_cout  = cout;
        end
    end

    // Drives one beat and returns just after the edge that accepted it.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic su);
        logic accepted;
        x        = a;
        y        = b;
        cin      = ci;
        sub      = su;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic runSingle(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic ci, input logic su, input logic [31:0] exp_sum,
                             input logic exp_cout, input logic exp_ovf);
        int lat;
        lat = 0;
        applyStimulus(a, b, ci, su);
        in_valid = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = i;
        end
        checkOutput({name, "_latency"}, 64'(lat), 64'(LATENCY));
        checkOutput({name, "_sum"}, {32'd0, sum}, {32'd0, exp_sum});
        checkOutput({name, "_cout"}, {63'd0, cout}, {63'd0, exp_cout});
`ifdef OVERFLOW_FLAG_EN
        checkOutput({name, "_ovf"}, {63'd0, ovf}, {63'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) $display("[TB] note: %s has undefined ovf expectation", name);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        int accepted;

        // Reset values, both during and just after reset.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_sum", {32'd0, sum}, 64'd0);
        checkOutput("reset_cout", {63'd0, cout}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("post_reset_out_valid", {63'd0, out_valid}, 64'd0);

        // Directed single beats with hand-computed results.
        runSingle("add", 32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
        runSingle("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        runSingle("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        runSingle("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        runSingle("sub_cin", 32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0);

        // Streaming: 20 back-to-back random beats.
        xfer_count = 0;
        max_run    = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("stream_count", 64'(xfer_count), 64'd20);
        checkOutput("stream_contiguous", 64'(max_run), 64'd20);

        // Backpressure: fill the pipe with out_ready low, hold, then drain.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        accepted  = 0;
        for (int i = 0; i < 20; i++) begin
            x   = $urandom;
            y   = $urandom;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!in_ready) break;
            accepted++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("fill_count", 64'(accepted), 64'(LATENCY + 1));
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
            checkOutput("bp_out_valid", {63'd0, out_valid}, 64'd1);
            @(posedge clk);
            #1;
        end
        xfer_count = 0;
        out_ready  = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("drain_count", 64'(xfer_count), 64'(accepted));
        checkOutput("drain_empty", 64'(expq.size()), 64'd0);

        // Reset with beats in flight.
        for (int i = 0; i < 4; i++) applyStimulus($urandom, $urandom, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        checkOutput("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midreset_sum", {32'd0, sum}, 64'd0);
        checkOutput("midreset_cout", {63'd0, cout}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        xfer_count = 0;
        checkOutput("rerelease_in_ready", {63'd0, in_ready}, 64'd1);
        runSingle("after_reset", 32'h1, 32'h2, 1'b0, 1'b0, 32'h3, 1'b0, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("no_stale_results", 64'(xfer_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised successor to the team's fixed 32-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into CHUNK-bit slices, one slice per pipeline stage, with a registered carry between stages.
- Supports back-to-back operands, a subtract mode, and valid/ready flow control with backpressure.
- Sits between operand registers and the writeback path in the ALU datapath, wherever a single-cycle ripple carry misses timing.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK, with STAGES >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- cin  input  1  carry-in (borrow-in when sub=1)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  result
- cout  output  1  carry-out of the MSB slice

Behaviour:
- Arithmetic, all modulo 2^WIDTH: {cout,sum} = x + (y ^ {WIDTH{sub}}) + (cin ^ sub).
  - sub=1, cin=0 gives x - y.
  - sub=1, cin=1 gives x - y - 1.
  - cout=1 on subtract means no borrow.
- Stage k (0..STAGES-1) adds slice k, bits [k*CHUNK +: CHUNK], using the carry registered from stage k-1. Stage 0 uses cin^sub.
- Input skew: slice k of x and of the conditionally inverted y is delayed k cycles before stage k.
- Output deskew: finished slices are held until the MSB slice completes, so all sum bits and cout leave together.
- Latency: a beat accepted at edge N presents out_valid=1 with its result after edge N+STAGES, given no stall.
- Throughput: one beat per cycle.
- Handshake:
  - A beat is accepted on an edge where in_valid && in_ready.
  - A result transfers on an edge where out_valid && out_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall. This is combinational and in_ready does not depend on in_valid.
  - While stalled, every pipeline register (data, carries, per-stage valid) holds, and sum/cout/out_valid stay stable.
  - Bubbles (in_valid=0) propagate as valid=0 and are never presented.
  - While out_valid=0, in_ready=1 and bubbles in the pipe are not compressed.
  - Once asserted, out_valid stays high until the transfer completes.
- Ordering: results leave strictly in acceptance order; no beat is dropped or duplicated.
- Reset:
  - rst_n low clears every stage valid, data and carry register asynchronously.
  - Outputs: out_valid=0, sum=0, cout=0, in_ready=1 once reset is released.
  - Beats in flight at reset are discarded.
- STAGES=1: single registered add, latency 1.
- Simultaneous events: acceptance and output transfer on the same edge are legal at full rate.

Optional Feature:
- Macro OVERFLOW_FLAG_EN.
- When defined: adds output port ovf (1 bit), aligned with sum and reset to 0. ovf = signed two's-complement overflow of the operation = carry into the MSB XOR carry out of the MSB, computed in the final stage.
- When undefined: the ovf port and its logic are absent; all other behaviour is unchanged.

Test Plan (WIDTH=32, CHUNK=4, latency 8):
- Add: x=0x0000_000F, y=0x0000_0001, cin=0, sub=0, single beat -> out_valid 8 cycles after accept; sum=0x0000_0010, cout=0.
- Full carry ripple: x=0xFFFF_FFFF, y=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1. With OVERFLOW_FLAG_EN, ovf=0.
- Subtract: x=5, y=7, sub=1, cin=0 -> sum=0xFFFF_FFFE, cout=0 (borrow). Then x=0x8000_0000, y=1, sub=1 -> sum=0x7FFF_FFFF, cout=1, ovf=1.
- Streaming: 20 back-to-back random beats with out_ready=1 -> 20 results on 20 consecutive cycles, in order, each matching the reference model.
- Backpressure: with the pipe full, hold out_ready=0 for 5 cycles -> in_ready=0 and sum/cout/out_valid frozen. After release, the remaining results drain in order with no loss.
- Reset mid-stream: assert rst_n=0 with 4 beats in flight -> out_valid=0 and sum=0 immediately. After release, a new beat is 0x1+0x2 -> sum=0x3 after 8 cycles, with no stale results emitted.
